// File: rtl/weight_buffer_feeder_if.sv
// Write-side valid/ready handshake carrying packed 32-bit weight words into the feeder.
interface weight_buffer_feeder_if;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;

    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready
    );
endinterface

// File: rtl/weight_buffer_feeder.sv
// Buffers packed weight words and holds each on `buffer` for one unpacking group, tracking the
// unpacker's phase so slice_valid/slice_idx line up with the unpacked output.
module weight_buffer_feeder #(
    parameter int unsigned FifoDepth = 8,
    parameter int unsigned AddrW     = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [1:0]           input_bitwidth_i,
    weight_buffer_feeder_if.slave wr_if,
    output logic [31:0]          buffer_o,
    output logic                 buffer_valid_o,
    output logic                 slice_valid_o,
    output logic [1:0]           slice_idx_o,
    output logic [AddrW:0]       fifo_count_o
);

    localparam logic [AddrW:0] FullCount = (AddrW + 1)'(FifoDepth);

    logic [31:0]      mem_q [FifoDepth];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]   count_q, count_d;
    logic [1:0]       phase_q, phase_d;
    logic [31:0]      buffer_q;
    logic             buffer_valid_q;
    logic             slice_valid_q;
    logic [1:0]       slice_idx_q;

    logic group_end;
    logic dead_slot;
    logic push, pop;

    always_comb begin
        phase_d   = phase_q;
        group_end = 1'b1;
        case (input_bitwidth_i)
            2'b00: begin
                phase_d   = phase_q;
                group_end = 1'b1;
            end
            2'b01: begin
                phase_d   = (phase_q == 2'd0) ? 2'd1 : 2'd0;
                group_end = (phase_q != 2'd0);
            end
            default: begin
                phase_d   = phase_q + 2'd1;
                group_end = (phase_q == 2'd3);
            end
        endcase
    end

    // 4-bit mode entered at phase 2/3: the unpacker does not update, so the slot is never valid.
    assign dead_slot = (input_bitwidth_i == 2'b01) && phase_q[1];

    assign wr_if.wr_ready = (count_q < FullCount);
    assign push           = wr_if.wr_valid && wr_if.wr_ready;
    assign pop            = group_end && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            mem_q[wr_ptr_q] <= wr_if.wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            phase_q        <= 2'd0;
            buffer_q       <= '0;
            buffer_valid_q <= 1'b0;
            slice_valid_q  <= 1'b0;
            slice_idx_q    <= 2'd0;
        end else begin
            phase_q       <= phase_d;
            count_q       <= count_d;
            slice_valid_q <= buffer_valid_q && !dead_slot;
            slice_idx_q   <= (input_bitwidth_i == 2'b00) ? 2'd0 : phase_q;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (group_end) begin
                if (pop) begin
                    buffer_q       <= mem_q[rd_ptr_q];
                    buffer_valid_q <= 1'b1;
                    rd_ptr_q       <= rd_ptr_q + 1'b1;
                end else begin
                    buffer_valid_q <= 1'b0;
                end
            end
        end
    end

    assign buffer_o       = buffer_q;
    assign buffer_valid_o = buffer_valid_q;
    assign slice_valid_o  = slice_valid_q;
    assign slice_idx_o    = slice_idx_q;
    assign fifo_count_o   = count_q;

endmodule

// File: tb/tb_weight_buffer_feeder.sv
// Directed and randomized stimulus for weight_buffer_feeder, checked every cycle against a
// queue-based model of the feeder's hold-per-group behaviour.
module tb_weight_buffer_feeder;

    logic        clk;
    logic        reset;
    logic [1:0]  bw;
    logic [31:0] buffer;
    logic        buffer_valid;
    logic        slice_valid;
    logic [1:0]  slice_idx;
    logic [3:0]  fifo_count;

    weight_buffer_feeder_if wr_if ();

    weight_buffer_feeder #(
        .FifoDepth (8),
        .AddrW     (3)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .input_bitwidth_i (bw),
        .wr_if            (wr_if.slave),
        .buffer_o         (buffer),
        .buffer_valid_o   (buffer_valid),
        .slice_valid_o    (slice_valid),
        .slice_idx_o      (slice_idx),
        .fifo_count_o     (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] mq [$];
    int          m_phase;
    logic [31:0] m_buf;
    bit          m_bv;
    bit          m_sv;
    int          m_idx;
    bit          m_push;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase = 0;
        m_buf   = 32'h0;
        m_bv    = 1'b0;
        m_sv    = 1'b0;
        m_idx   = 0;
        m_push  = 1'b0;
    endtask

    // Group length per mode: 1, 2 or 4 cycles; a group ends when the unpacker returns to phase 0.
    task automatic model_edge(input bit rst, input logic [1:0] b, input bit wv, input logic [31:0] wd);
        bit group_end;
        int next_phase;
        if (rst) begin
            model_reset();
            return;
        end
        m_push = wv && (mq.size() < 8);
        if (b == 2'b00) next_phase = m_phase;
        else if (b == 2'b01) next_phase = (m_phase == 0) ? 1 : 0;
        else next_phase = (m_phase + 1) % 4;
        group_end = (b == 2'b00) || (next_phase == 0);
        m_sv  = m_bv && !(b == 2'b01 && m_phase >= 2);
        m_idx = (b == 2'b00) ? 0 : m_phase;
        if (group_end) begin
            if (mq.size() > 0) begin
                m_buf = mq.pop_front();
                m_bv  = 1'b1;
            end else begin
                m_bv = 1'b0;
            end
        end
        if (m_push) mq.push_back(wd);
        m_phase = next_phase;
    endtask

    task automatic step(input bit rst, input logic [1:0] b, input bit wv, input logic [31:0] wd);
        reset          = rst;
        bw             = b;
        wr_if.wr_valid = wv;
        wr_if.wr_data  = wd;
        @(posedge clk);
        model_edge(rst, b, wv, wd);
        #1;
        chk("buffer", buffer, m_buf);
        chk("buffer_valid", {31'b0, buffer_valid}, {31'b0, m_bv});
        chk("slice_valid", {31'b0, slice_valid}, {31'b0, m_sv});
        chk("slice_idx", {30'b0, slice_idx}, 32'(m_idx));
        chk("fifo_count", {28'b0, fifo_count}, 32'(mq.size()));
        chk("wr_ready", {31'b0, wr_if.wr_ready}, {31'b0, (mq.size() < 8)});
    endtask

    initial begin
        logic [31:0] words [12];
        int          sent;
        int          guard;
        logic [1:0]  rb;

        reset          = 1'b1;
        bw             = 2'b00;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 32'h0;
        model_reset();

        // Reset state
        step(1, 2'b00, 0, 32'h0);
        step(1, 2'b00, 0, 32'h0);
        step(0, 2'b00, 0, 32'h0);

        // 8-bit: one word per cycle
        step(0, 2'b00, 1, 32'h11111111);
        step(0, 2'b00, 1, 32'h22222222);
        step(0, 2'b00, 1, 32'h33333333);
        for (int i = 0; i < 4; i++) step(0, 2'b00, 0, 32'h0);

        // 4-bit: each word held two cycles
        step(0, 2'b01, 1, 32'hDDCCBBAA);
        for (int i = 0; i < 6; i++) step(0, 2'b01, 0, 32'h0);

        // 2-bit with an idle gap
        step(0, 2'b10, 1, 32'h44332211);
        for (int i = 0; i < 6; i++) step(0, 2'b10, 0, 32'h0);
        step(0, 2'b10, 1, 32'h88776655);
        for (int i = 0; i < 10; i++) step(0, 2'b10, 0, 32'h0);

        // Backpressure: wr_valid held high in 2-bit mode
        for (int i = 0; i < 12; i++) words[i] = 32'hA0000000 + 32'(i) * 32'h01010101;
        sent  = 0;
        guard = 0;
        while (sent < 12 && guard < 200) begin
            step(0, 2'b10, 1, words[sent]);
            if (m_push) sent++;
            guard++;
        end
        chk("backpressure_sent", 32'(sent), 32'd12);
        for (int i = 0; i < 60; i++) step(0, 2'b10, 0, 32'h0);

        // Switch 2-bit -> 4-bit at phase 2 while a word is held
        step(0, 2'b10, 1, 32'hCAFEF00D);
        step(0, 2'b10, 1, 32'h0BADBEEF);
        guard = 0;
        while (!(m_phase == 2 && m_bv) && guard < 16) begin
            step(0, 2'b10, 0, 32'h0);
            guard++;
        end
        chk("switch_reached_phase2", 32'(m_phase), 32'd2);
        for (int i = 0; i < 8; i++) step(0, 2'b01, 0, 32'h0);

        // Reset mid-stream in 4-bit mode
        for (int i = 0; i < 6; i++) step(0, 2'b01, 1, 32'h50000000 + 32'(i));
        step(1, 2'b01, 0, 32'h0);
        step(0, 2'b01, 0, 32'h0);
        step(0, 2'b01, 1, 32'h12345678);
        for (int i = 0; i < 6; i++) step(0, 2'b01, 0, 32'h0);

        // Randomized traffic with mode switches and occasional resets
        rb = 2'b00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) rb = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 99) == 0), rb, ($urandom_range(0, 2) != 0), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
